// File: rtl/decode_sched.sv
// Instruction queue and hazard-aware issue scheduler between fetch, decode and execute.
// Holds fetched words in a FIFO and tracks pending destination registers to block RAW/WAW issue.
module decode_sched #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_fetch_valid,
    input  logic [31:0]              i_fetch_instr,
    output logic                     o_fetch_ready,
    output logic [31:0]              o_dec_instr,
    output logic                     o_dec_imask,
    input  logic [14:0]              i_dec_regs,
    input  logic                     i_dec_rs1_en,
    input  logic                     i_dec_rs2_en,
    input  logic                     i_dec_rd_en,
    output logic                     o_issue_valid,
    input  logic                     i_issue_ready,
    input  logic                     i_wb_en,
    input  logic [4:0]               i_wb_rd,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [CNTW-1:0]          o_stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_READY,
        ST_BLOCKED,
        ST_FLUSH
    } status_t;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     sb;
    logic [31:0]     sb_eff;
    logic [31:0]     sb_next;
    logic [31:0]     wb_mask;
    logic [CNTW-1:0] stall_cnt;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            hazard;
    logic            push;
    logic            pop;
    status_t         status;

    assign rs1 = i_dec_regs[4:0];
    assign rs2 = i_dec_regs[9:5];
    assign rd  = i_dec_regs[14:10];

    // A writeback landing this cycle releases its register before the hazard check.
    assign wb_mask = i_wb_en ? (32'd1 << i_wb_rd) : 32'd0;
    assign sb_eff  = sb & ~wb_mask;

    assign hazard = (i_dec_rs1_en && (rs1 != 5'd0) && sb_eff[rs1]) ||
                    (i_dec_rs2_en && (rs2 != 5'd0) && sb_eff[rs2]) ||
                    (i_dec_rd_en  && (rd  != 5'd0) && sb_eff[rd]);

    always_comb begin
        status = ST_EMPTY;
        if (count != '0) begin
            if (i_flush)
                status = ST_FLUSH;
            else if (hazard)
                status = ST_BLOCKED;
            else
                status = ST_READY;
        end
    end

    assign o_dec_imask   = (count != '0);
    assign o_dec_instr   = (count != '0) ? mem[rd_ptr] : NOP;
    assign o_issue_valid = (status == ST_READY);
    assign o_stall       = (status == ST_BLOCKED);
    assign o_fetch_ready = (count != CW'(DEPTH)) && !i_flush;
    assign o_count       = count;
    assign o_stall_cnt   = stall_cnt;

    assign push = i_fetch_valid && o_fetch_ready;
    assign pop  = o_issue_valid && i_issue_ready;

    // Issue set is applied after the writeback clear so it wins on a collision.
    always_comb begin
        sb_next = sb_eff;
        if (pop && i_dec_rd_en && (rd != 5'd0))
            sb_next[rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_fetch_instr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sb        <= '0;
            stall_cnt <= '0;
        end else begin
            sb <= sb_next;
            if (o_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNTW'(1);
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_sched.sv
// Directed bench for decode_sched: a decode model feeds register fields back,
// and a negedge monitor compares each issued word against an expected-issue queue.
module tb_decode_sched;

    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] dec_instr;
    logic        dec_imask;
    logic [14:0] dec_regs;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_en;
    logic        issue_valid;
    logic        issue_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [$clog2(DEPTH):0] count;
    logic [CNTW-1:0] stall_cnt;
    logic [6:0]  opc;

    int checks = 0;
    int fails  = 0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    decode_sched #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetch_valid(fetch_valid), .i_fetch_instr(fetch_instr), .o_fetch_ready(fetch_ready),
        .o_dec_instr(dec_instr), .o_dec_imask(dec_imask),
        .i_dec_regs(dec_regs), .i_dec_rs1_en(rs1_en), .i_dec_rs2_en(rs2_en), .i_dec_rd_en(rd_en),
        .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
        .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_flush(flush),
        .o_stall(stall), .o_count(count), .o_stall_cnt(stall_cnt)
    );

    // Minimal RV32 field decoder standing in for the decode block
    always_comb begin
        opc      = dec_instr[6:0];
        dec_regs = {dec_instr[11:7], dec_instr[24:20], dec_instr[19:15]};
        rs1_en   = 1'b0;
        rs2_en   = 1'b0;
        rd_en    = 1'b0;
        case (opc)
            7'h13: begin rd_en = 1'b1; rs1_en = 1'b1; end
            7'h23: begin rs1_en = 1'b1; rs2_en = 1'b1; end
            7'h33: begin rd_en = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; end
            7'h37: rd_en = 1'b1;
            7'h6f: rd_en = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL issue_unexpected: got %h expected no issue", dec_instr);
            end else begin
                chk("issue_order", dec_instr, expq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd1);
        chk({tag, "_imask"}, 32'(dec_imask), 32'd0);
        chk({tag, "_issue_valid"}, 32'(issue_valid), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_dec_instr"}, dec_instr, 32'h00000013);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    function automatic logic [31:0] swk(input int k);
        return 32'h00000023 | (32'(k) << 7);
    endfunction

    initial begin
        rst_n = 1'b1;
        fetch_valid = 1'b0; fetch_instr = '0; issue_ready = 1'b0;
        wb_en = 1'b0; wb_rd = '0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_chk("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // addi sp,sp,-32
        fetch_valid = 1'b1; fetch_instr = 32'hfe010113; expq.push_back(32'hfe010113);
        tick();
        fetch_valid = 1'b0;
        chk("t1_head", dec_instr, 32'hfe010113);
        chk("t1_imask", 32'(dec_imask), 32'd1);
        chk("t1_issue_valid", 32'(issue_valid), 32'd1);
        issue_ready = 1'b1;
        tick();
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_nop", dec_instr, 32'h00000013);

        // sw ra,28(sp) stalls on x2 until writeback
        fetch_valid = 1'b1; fetch_instr = 32'h00112e23; expq.push_back(32'h00112e23);
        tick();
        fetch_valid = 1'b0;
        chk("t2_stall", 32'(stall), 32'd1);
        chk("t2_no_issue", 32'(issue_valid), 32'd0);
        tick(); tick(); tick();
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("t2_stall_held", 32'(stall), 32'd1);
        wb_en = 1'b1; wb_rd = 5'd2;
        #1;
        chk("t2_bypass_valid", 32'(issue_valid), 32'd1);
        chk("t2_bypass_stall", 32'(stall), 32'd0);
        tick();
        wb_en = 1'b0;
        chk("t2_count", 32'(count), 32'd0);
        chk("t2_cnt_hold", 32'(stall_cnt), 32'd3);

        // jal x0
        fetch_valid = 1'b1; fetch_instr = 32'h01c0006f; expq.push_back(32'h01c0006f);
        tick();
        fetch_valid = 1'b0;
        chk("t3_issue_valid", 32'(issue_valid), 32'd1);
        tick();
        chk("t3_count", 32'(count), 32'd0);

        // Fill with backpressure; w0 reads x2 and so also proves sb[2] was released
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fetch_valid = 1'b1;
            fetch_instr = (k == 0) ? 32'h00112e23 : swk(k);
            if (k < 4) expq.push_back(fetch_instr);
            chk("t4_ready", 32'(fetch_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            chk("t4_count", 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
        end
        chk("t4_full_ready", 32'(fetch_ready), 32'd0);
        chk("t4_full_valid", 32'(issue_valid), 32'd1);
        chk("t4_bp_stall", 32'(stall), 32'd0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t4_pop_count", 32'(count), 32'd3);
        chk("t4_pop_ready", 32'(fetch_ready), 32'd1);
        issue_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fetch_valid = 1'b1; fetch_instr = swk(k + 8); expq.push_back(fetch_instr);
            tick();
            chk("t4_pair_count", 32'(count), 32'd3);
        end
        fetch_valid = 1'b0;
        tick(); tick(); tick();
        chk("t4_drain", 32'(count), 32'd0);

        // addi x5,x0,0 marks x5 pending, then flush three queued entries
        fetch_valid = 1'b1; fetch_instr = 32'h00000293; expq.push_back(32'h00000293);
        tick();
        fetch_valid = 1'b0;
        chk("t5_issue_valid", 32'(issue_valid), 32'd1);
        tick();
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetch_valid = 1'b1; fetch_instr = swk(k + 20);
            tick();
        end
        fetch_valid = 1'b0;
        chk("t5_pre_count", 32'(count), 32'd3);
        issue_ready = 1'b1; flush = 1'b1; fetch_valid = 1'b1; fetch_instr = 32'h00000093;
        #1;
        chk("t5_flush_ready", 32'(fetch_ready), 32'd0);
        chk("t5_flush_valid", 32'(issue_valid), 32'd0);
        chk("t5_flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_imask", 32'(dec_imask), 32'd0);
        fetch_valid = 1'b1; fetch_instr = 32'h00028313; expq.push_back(32'h00028313);
        tick();
        fetch_valid = 1'b0;
        chk("t5_sb5_kept", 32'(stall), 32'd1);
        tick();
        chk("t5_stall_cnt", 32'(stall_cnt), 32'd4);
        wb_en = 1'b1; wb_rd = 5'd5;
        #1;
        chk("t5_wb_release", 32'(issue_valid), 32'd1);
        tick();
        wb_en = 1'b0;
        chk("t5_done", 32'(count), 32'd0);

        // addi x7,x6,0 stalls on x6; reset arrives asynchronously mid-cycle
        fetch_valid = 1'b1; fetch_instr = 32'h00030393;
        tick();
        fetch_valid = 1'b0;
        chk("t6_stall", 32'(stall), 32'd1);
        tick();
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd5);
        #2 rst_n = 1'b0;
        #1 rst_chk("async");
        tick();
        rst_n = 1'b1;
        fetch_valid = 1'b1; fetch_instr = 32'h00030393; expq.push_back(32'h00030393);
        tick();
        fetch_valid = 1'b0;
        chk("t6_sb_cleared", 32'(issue_valid), 32'd1);
        tick();
        chk("t6_count", 32'(count), 32'd0);
        tick();
        chk("expq_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
